// File: rtl/gnn_layer_engine.sv
`default_nettype none
// ============================================================================
// Module   : gnn_layer_engine
// Purpose  : Time-multiplexed single GCN layer. Computes an adjacency-masked
//            neighbour sum, then a dense MAC, then an optional ReLU.
//            One shared aggregate/MAC pipe sits behind a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module gnn_layer_engine #(
  parameter int  NUM_NODES = 4,
  parameter int  IN_FEAT   = 4,
  parameter int  OUT_FEAT  = 4,
  parameter int  IN_WIDTH  = 5,
  parameter int  W_WIDTH   = 5,
  localparam int AGG_W     = IN_WIDTH + $clog2(NUM_NODES),
  localparam int ACC_W     = AGG_W + W_WIDTH + $clog2(IN_FEAT)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_NODES*IN_FEAT*IN_WIDTH-1:0] x_flat,
  input  logic [IN_FEAT*OUT_FEAT*W_WIDTH-1:0]   w_flat,
  input  logic [NUM_NODES*NUM_NODES-1:0]        adj,
  input  logic                                  relu_en,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NUM_NODES*OUT_FEAT*ACC_W-1:0]   y_flat,
  output logic                                  busy
);

  localparam int NW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int OW = (OUT_FEAT > 1) ? $clog2(OUT_FEAT) : 1;
  localparam logic [NW-1:0] NODE_LAST = NW'(NUM_NODES - 1);
  localparam logic [OW-1:0] OUT_LAST  = OW'(OUT_FEAT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AGG  = 2'd1;
  localparam logic [1:0] S_MAC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [NW-1:0] node_q, node_d;
  logic [OW-1:0] out_q, out_d;

  // Unpacked views of the flat input buses
  logic signed [IN_WIDTH-1:0] x_in [NUM_NODES][IN_FEAT];
  logic signed [W_WIDTH-1:0]  w_in [IN_FEAT][OUT_FEAT];
  logic [NUM_NODES-1:0]       adj_in [NUM_NODES];

  // Transaction latches, captured on accept
  logic signed [IN_WIDTH-1:0] x_q [NUM_NODES][IN_FEAT];
  logic signed [W_WIDTH-1:0]  w_q [IN_FEAT][OUT_FEAT];
  logic [NUM_NODES-1:0]       adj_q [NUM_NODES];
  logic                       relu_q;

  logic signed [AGG_W-1:0] agg_q [NUM_NODES][IN_FEAT];
  logic signed [AGG_W-1:0] agg_row_d [IN_FEAT];
  logic signed [ACC_W-1:0] y_q [NUM_NODES][OUT_FEAT];
  logic signed [ACC_W-1:0] mac_acc_d;
  logic signed [ACC_W-1:0] mac_res_d;

  // Flat-bus unpacking and result packing
  for (genvar n = 0; n < NUM_NODES; n++) begin : g_node
    assign adj_in[n] = adj[n*NUM_NODES +: NUM_NODES];
    for (genvar f = 0; f < IN_FEAT; f++) begin : g_xfeat
      assign x_in[n][f] = x_flat[(n*IN_FEAT+f)*IN_WIDTH +: IN_WIDTH];
    end
    for (genvar o = 0; o < OUT_FEAT; o++) begin : g_yout
      assign y_flat[(n*OUT_FEAT+o)*ACC_W +: ACC_W] = y_q[n][o];
    end
  end

  for (genvar f = 0; f < IN_FEAT; f++) begin : g_wfeat
    for (genvar o = 0; o < OUT_FEAT; o++) begin : g_wout
      assign w_in[f][o] = w_flat[(f*OUT_FEAT+o)*W_WIDTH +: W_WIDTH];
    end
  end

  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_AGG) || (state_q == S_MAC);

  // Aggregate one node row: sign-extended sum of every neighbour selected by adj
  always_comb begin
    for (int f = 0; f < IN_FEAT; f++) begin
      agg_row_d[f] = '0;
      for (int j = 0; j < NUM_NODES; j++) begin
        if (adj_q[node_q][j]) begin
          agg_row_d[f] = agg_row_d[f] + AGG_W'(x_q[j][f]);
        end
      end
    end
  end

  // One (node, out-feature) dot product, ReLU applied to negative results when enabled
  always_comb begin
    mac_acc_d = '0;
    for (int f = 0; f < IN_FEAT; f++) begin
      mac_acc_d = mac_acc_d + ACC_W'(agg_q[node_q][f]) * ACC_W'(w_q[f][out_q]);
    end
    mac_res_d = (relu_q && mac_acc_d[ACC_W-1]) ? '0 : mac_acc_d;
  end

  // Sequencer: node counter in AGG, node-outer/out-inner counters in MAC
  always_comb begin
    state_d = state_q;
    node_d  = node_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_AGG;
          node_d  = '0;
          out_d   = '0;
        end
      end
      S_AGG: begin
        if (node_q == NODE_LAST) begin
          state_d = S_MAC;
          node_d  = '0;
        end else begin
          node_d = node_q + 1'b1;
        end
      end
      S_MAC: begin
        if (out_q == OUT_LAST) begin
          out_d = '0;
          if (node_q == NODE_LAST) begin
            state_d = S_DONE;
            node_d  = '0;
          end else begin
            node_d = node_q + 1'b1;
          end
        end else begin
          out_d = out_q + 1'b1;
        end
      end
      default: begin
        // DONE: a pending in_valid is deliberately ignored here
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State, latches, aggregate store and result store
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      node_q  <= '0;
      out_q   <= '0;
      relu_q  <= 1'b0;
      for (int n = 0; n < NUM_NODES; n++) begin
        adj_q[n] <= '0;
        for (int f = 0; f < IN_FEAT; f++) begin
          x_q[n][f]   <= '0;
          agg_q[n][f] <= '0;
        end
        for (int o = 0; o < OUT_FEAT; o++) begin
          y_q[n][o] <= '0;
        end
      end
      for (int f = 0; f < IN_FEAT; f++) begin
        for (int o = 0; o < OUT_FEAT; o++) begin
          w_q[f][o] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      node_q  <= node_d;
      out_q   <= out_d;
      if (state_q == S_IDLE && in_valid) begin
        relu_q <= relu_en;
        for (int n = 0; n < NUM_NODES; n++) begin
          adj_q[n] <= adj_in[n];
          for (int f = 0; f < IN_FEAT; f++) begin
            x_q[n][f] <= x_in[n][f];
          end
        end
        for (int f = 0; f < IN_FEAT; f++) begin
          for (int o = 0; o < OUT_FEAT; o++) begin
            w_q[f][o] <= w_in[f][o];
          end
        end
      end
      if (state_q == S_AGG) begin
        for (int f = 0; f < IN_FEAT; f++) begin
          agg_q[node_q][f] <= agg_row_d[f];
        end
      end
      if (state_q == S_MAC) begin
        y_q[node_q][out_q] <= mac_res_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gnn_layer_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_gnn_layer_engine
// Purpose  : Directed, scoreboard-checked bench for gnn_layer_engine at the
//            default geometry (4 nodes, 4 in/out features, 5-bit operands).
// Revision : 1.0  initial release
// ============================================================================
module tb_gnn_layer_engine;

  localparam int NN  = 4;
  localparam int IFT = 4;
  localparam int OFT = 4;
  localparam int IW  = 5;
  localparam int WW  = 5;
  localparam int AW  = 14;
  localparam int XB  = NN*IFT*IW;
  localparam int WB  = IFT*OFT*WW;
  localparam int YB  = NN*OFT*AW;
  localparam int LAT = NN*(1+OFT);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [XB-1:0] x_flat;
  logic [WB-1:0] w_flat;
  logic [NN*NN-1:0] adj;
  logic          relu_en;
  logic          out_valid;
  logic          out_ready;
  logic [YB-1:0] y_flat;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [YB-1:0] sb [$];

  gnn_layer_engine #(
    .NUM_NODES(NN), .IN_FEAT(IFT), .OUT_FEAT(OFT), .IN_WIDTH(IW), .W_WIDTH(WW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_flat(x_flat), .w_flat(w_flat), .adj(adj), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .y_flat(y_flat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every output entry set to the same value
  function automatic logic [YB-1:0] y_all(input int v);
    logic [YB-1:0] r;
    r = '0;
    for (int k = 0; k < NN*OFT; k++) r[k*AW +: AW] = AW'(v);
    return r;
  endfunction

  function automatic logic [XB-1:0] x_all(input int v);
    logic [XB-1:0] r;
    r = '0;
    for (int k = 0; k < NN*IFT; k++) r[k*IW +: IW] = IW'(v);
    return r;
  endfunction

  function automatic logic [WB-1:0] w_all(input int v);
    logic [WB-1:0] r;
    r = '0;
    for (int k = 0; k < IFT*OFT; k++) r[k*WW +: WW] = WW'(v);
    return r;
  endfunction

  function automatic logic [WB-1:0] w_ident();
    logic [WB-1:0] r;
    r = '0;
    for (int f = 0; f < IFT; f++)
      for (int o = 0; o < OFT; o++)
        r[(f*OFT+o)*WW +: WW] = (f == o) ? WW'(1) : WW'(0);
    return r;
  endfunction

  // Monitor: pops the oldest expected result on every output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got result with empty scoreboard");
      end else begin
        chk("y_flat", 256'(y_flat), 256'(sb.pop_front()));
      end
    end
  end

  // Issue one transaction; optionally wait for the result and measure latency
  task automatic issue(input logic [XB-1:0] x, input logic [WB-1:0] w,
                       input logic [NN*NN-1:0] a, input logic r,
                       input logic [YB-1:0] ey, input bit push, input bit wait_done);
    int cnt;
    x_flat = x; w_flat = w; adj = a; relu_en = r; in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 100) begin step(); cnt++; end
    chk("accept_ready", 256'(in_ready), 256'(1));
    step();
    in_valid = 1'b0;
    if (push) sb.push_back(ey);
    if (wait_done) begin
      cnt = 0;
      while (!out_valid && cnt < 100) begin step(); cnt++; end
      chk("latency", 256'(cnt), 256'(LAT));
    end
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 100) begin step(); cnt++; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [XB-1:0] xv;
    logic [YB-1:0] ey, eyr, yhold;
    int err;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; relu_en = 1'b0;
    x_flat = '0; w_flat = '0; adj = '0;
    step(); step();
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_y", 256'(y_flat), 256'(0));
    chk("rst_in_ready_low", 256'(in_ready), 256'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 256'(in_ready), 256'(1));

    // Self-loops, identity weights, x[n][f]=n-f  ->  y[n][o]=n-o
    xv = '0; ey = '0; eyr = '0;
    for (int n = 0; n < NN; n++) begin
      for (int f = 0; f < IFT; f++) xv[(n*IFT+f)*IW +: IW] = IW'(n-f);
      for (int o = 0; o < OFT; o++) begin
        ey[(n*OFT+o)*AW +: AW]  = AW'(n-o);
        eyr[(n*OFT+o)*AW +: AW] = (n > o) ? AW'(n-o) : AW'(0);
      end
    end
    issue(xv, w_ident(), 16'h8421, 1'b0, ey, 1, 1);
    drain();

    // Reset in the middle of MAC discards the transaction and clears y
    issue(x_all(-16), w_all(-16), 16'hFFFF, 1'b0, '0, 0, 0);
    repeat (9) step();
    chk("mid_busy_before_rst", 256'(busy), 256'(1));
    rst_n = 1'b0;
    repeat (3) step();
    chk("mid_rst_out_valid", 256'(out_valid), 256'(0));
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_y", 256'(y_flat), 256'(0));
    rst_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", 256'(in_ready), 256'(1));

    // Extremes: agg=-64, y = 4 * (-64 * -16) = 4096
    issue(x_all(-16), w_all(-16), 16'hFFFF, 1'b0, y_all(4096), 1, 1);
    drain();
    // agg=-64, y = 4 * (-64 * 15) = -3840, and ReLU clamps to 0
    issue(x_all(-16), w_all(15), 16'hFFFF, 1'b0, y_all(-3840), 1, 1);
    drain();
    issue(x_all(-16), w_all(15), 16'hFFFF, 1'b1, y_all(0), 1, 1);
    drain();
    // ReLU on the mixed-sign pattern keeps only n>o entries
    issue(xv, w_ident(), 16'h8421, 1'b1, eyr, 1, 1);
    drain();

    // Row 2 of adj empty: all-ones x, identity W -> y=4 except node 2 = 0
    ey = y_all(4);
    for (int o = 0; o < OFT; o++) ey[(2*OFT+o)*AW +: AW] = '0;
    issue(x_all(1), w_ident(), 16'hF0FF, 1'b0, ey, 1, 1);
    drain();

    // Backpressure: result held stable, inputs ignored while in DONE
    out_ready = 1'b0;
    issue(x_all(-16), w_all(-16), 16'hFFFF, 1'b0, y_all(4096), 1, 1);
    yhold = y_flat;
    err = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      x_flat = x_all(3); w_flat = w_all(2); adj = 16'h1111;
      step();
      if (y_flat !== yhold || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) err++;
    end
    chk("hold_stable_errors", 256'(err), 256'(0));
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    chk("handshake_out_valid", 256'(out_valid), 256'(0));
    chk("handshake_in_ready", 256'(in_ready), 256'(1));
    chk("handshake_y_kept", 256'(y_flat), 256'(yhold));
    in_valid = 1'b0;
    step();
    chk("no_accept_in_done", 256'(busy), 256'(0));

    repeat (3) step();
    chk("scoreboard_empty", 256'(sb.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
